// File: rtl/op_sequencer_if.sv
// rtl/op_sequencer_if.sv - host/cpu-facing signal bundle of the op sequencer
//
// Purpose: groups every non-clock/reset port of op_sequencer.
//   master : environment side (host/loader pushes ops, cpu returns done_out)
//   slave  : the sequencer itself
// Signals:
//   in_valid/in_ready/in_op : op push handshake from the host
//   start                   : one-cycle pulse, begin draining the queue
//   op/done_out             : op word to the cpu and its completion flag
//   busy/all_done           : run status and normal-drain pulse
//   error_timeout           : sticky timeout flag
//   issued_count/fifo_level : ops issued since reset, entries queued
interface op_sequencer_if #(
  parameter int OP_W  = 32,
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic             start;
  logic [OP_W-1:0]  op;
  logic             done_out;
  logic             busy;
  logic             all_done;
  logic             error_timeout;
  logic [CNT_W-1:0] issued_count;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output in_valid, in_op, start, done_out,
    input  in_ready, op, busy, all_done, error_timeout, issued_count, fifo_level
  );

  modport slave (
    input  in_valid, in_op, start, done_out,
    output in_ready, op, busy, all_done, error_timeout, issued_count, fifo_level
  );
endinterface

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - queued op issuer that feeds the cpu one op at a time
//
// Purpose: buffers op words pushed by the host in a DEPTH-entry FIFO and, after
// a start pulse, issues them one by one to the cpu, waiting for done_out after
// each. Ops are opaque words of OP_W bits.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : op_sequencer_if slave modport (push handshake, op/done_out, status)
module op_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16,
  parameter int OP_W    = 32
) (
  input  logic           clk,
  input  logic           reset,
  op_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t           state, state_nx;
  logic [OP_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [TW-1:0]    tmo_cnt;
  logic [OP_W-1:0]  op_reg;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop, tmo_hit;

  assign bus.in_ready      = (level != LW'(DEPTH));
  assign bus.fifo_level    = level;
  assign bus.issued_count  = cnt_q;
  assign bus.error_timeout = err_q;

  assign push    = bus.in_valid && bus.in_ready;
  assign tmo_hit = (state == S_WAIT) && !bus.done_out && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // done_out and the level test in WAIT use the registered level, so an op
  // pushed in the same cycle as done_out is picked up on the next pass.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start && level != '0) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.done_out)  state_nx = (level != '0) ? S_ISSUE : S_FINISH;
        else if (tmo_hit)  state_nx = S_IDLE;
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    bus.op       = '0;
    bus.busy     = (state != S_IDLE);
    bus.all_done = 1'b0;
    case (state)
      S_ISSUE:  pop          = 1'b1;
      S_WAIT:   bus.op       = op_reg;
      S_FINISH: bus.all_done = 1'b1;
      default: ;
    endcase
  end

  // Storage has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_op;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      tmo_cnt <= '0;
      op_reg  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);

      // A timeout flush discards everything queued before this cycle, but an
      // op accepted in the flush cycle itself is kept: the host saw in_ready.
      if (tmo_hit) begin
        err_q  <= 1'b1;
        rd_ptr <= wr_ptr;
        level  <= push ? LW'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (!push && pop) level <= level - LW'(1);
      end

      if (pop) begin
        op_reg <= mem[rd_ptr];
        cnt_q  <= cnt_q + CNT_W'(1);
      end

      if (state == S_ISSUE)                     tmo_cnt <= '0;
      else if (state == S_WAIT && !bus.done_out) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - randomized and directed bench for op_sequencer
module tb_op_sequencer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;
  localparam int OP_W    = 32;

  // Reference phases: the run is idle, in the one-cycle NOP slot before an op
  // shows, showing an op, or in the one-cycle completion pulse.
  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_SHOW = 2;
  localparam int P_FIN  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  op_sequencer_if #(.OP_W(OP_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [OP_W-1:0]  mq[$];
  int               phase;
  logic [OP_W-1:0]  cur;
  int               waited;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;
  bit               last_acc;

  int               done_pulses;
  logic [OP_W-1:0]  seen[$];
  logic [OP_W-1:0]  prev_op;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk_op(input logic [7:0] mode, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c,
                                        input logic [3:0] d, input logic [3:0] e,
                                        input logic [3:0] f);
    return {mode, a, b, c, d, e, f};
  endfunction

  function automatic bit resp(input int delay);
    return (phase == P_SHOW) && (waited >= delay);
  endfunction

  task automatic model_clear();
    mq.delete();
    phase    = P_IDLE;
    waited   = 0;
    m_err    = 1'b0;
    m_cnt    = '0;
    last_acc = 1'b0;
  endtask

  // One clock: compare outputs against the reference, apply inputs, clock,
  // then advance the reference with the inputs the DUT just sampled.
  task automatic step(input bit v, input logic [31:0] d, input bit s, input bit dn, input bit r);
    logic [OP_W-1:0] exp_op;
    bit acc;
    bit had;
    exp_op = (phase == P_SHOW) ? cur : '0;
    check("op",            64'(bus.op),            64'(exp_op));
    check("busy",          64'(bus.busy),          64'(phase != P_IDLE));
    check("all_done",      64'(bus.all_done),      64'(phase == P_FIN));
    check("in_ready",      64'(bus.in_ready),      64'(mq.size() < DEPTH));
    check("fifo_level",    64'(bus.fifo_level),    64'(mq.size()));
    check("issued_count",  64'(bus.issued_count),  64'(m_cnt));
    check("error_timeout", 64'(bus.error_timeout), 64'(m_err));
    if (bus.all_done === 1'b1) done_pulses++;
    if (bus.op != '0 && prev_op == '0) seen.push_back(bus.op);
    prev_op = bus.op;

    bus.in_valid = v;
    bus.in_op    = d;
    bus.start    = s;
    bus.done_out = dn;
    reset        = r;
    @(posedge clk);
    #1;

    if (r) begin
      model_clear();
    end else begin
      acc = v && (mq.size() < DEPTH);
      had = (mq.size() > 0);
      case (phase)
        P_IDLE: if (s && had) phase = P_GAP;
        P_GAP: begin
          cur    = mq.pop_front();
          m_cnt  = m_cnt + 1'b1;
          waited = 0;
          phase  = P_SHOW;
        end
        P_SHOW: begin
          if (dn) phase = had ? P_GAP : P_FIN;
          else if (waited == TIMEOUT - 1) begin
            m_err = 1'b1;
            mq.delete();
            phase = P_IDLE;
          end else waited++;
        end
        default: phase = P_IDLE;
      endcase
      if (acc) mq.push_back(d);
      last_acc = acc;
    end
  endtask

  task automatic run(input int delay, input int limit);
    for (int i = 0; i < limit && phase != P_IDLE; i++) step(0, '0, 0, resp(delay), 0);
    check("drained_busy", 64'(bus.busy), 64'(0));
  endtask

  logic [31:0] op_a, op_b, op_c, pend;
  bit have;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.start    = 1'b0;
    bus.done_out = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    done_pulses = 0;
    prev_op     = '0;

    // reset state
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    check("rst_busy",     64'(bus.busy),         64'(0));
    check("rst_in_ready", 64'(bus.in_ready),     64'(1));
    check("rst_op",       64'(bus.op),           64'(0));
    check("rst_level",    64'(bus.fifo_level),   64'(0));

    // empty start and spurious done
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    check("empty_busy",   64'(bus.busy),         64'(0));
    check("empty_issued", 64'(bus.issued_count), 64'(0));
    check("empty_done",   64'(done_pulses),      64'(0));

    // basic run, done 4 cycles after each op shows
    op_a = mk_op(8'd1, 0, 0, 1, 1, 3, 3);
    op_b = mk_op(8'd2, 0, 0, 2, 2, 4, 4);
    op_c = mk_op(8'd1, 3, 3, 4, 4, 5, 5);
    seen.delete();
    step(1, op_a, 0, 0, 0);
    step(1, op_b, 0, 0, 0);
    step(1, op_c, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    run(4, 100);
    check("basic_issued", 64'(bus.issued_count), 64'(3));
    check("basic_alldone", 64'(done_pulses),     64'(1));
    check("basic_nops",   64'(seen.size()),      64'(3));
    if (seen.size() == 3) begin
      check("basic_op0", 64'(seen[0]), 64'(op_a));
      check("basic_op1", 64'(seen[1]), 64'(op_b));
      check("basic_op2", 64'(seen[2]), 64'(op_c));
    end

    // full FIFO: 9 back-to-back pushes, the 9th held until space appears
    step(0, '0, 0, 0, 1);
    done_pulses = 0;
    for (int i = 0; i < 9; i++) step(1, mk_op(8'h10 + 8'(i), 1, 2, 3, 4, 5, 6), 0, 0, 0);
    check("full_level",    64'(bus.fifo_level), 64'(8));
    check("full_in_ready", 64'(bus.in_ready),   64'(0));
    pend = mk_op(8'h18, 1, 2, 3, 4, 5, 6);
    step(1, pend, 1, 0, 0);
    check("issue_in_ready", 64'(bus.in_ready), 64'(0));
    step(1, pend, 0, 0, 0);
    check("after_issue_in_ready", 64'(bus.in_ready), 64'(1));
    step(1, pend, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check("ninth_accepted_level", 64'(bus.fifo_level), 64'(8));
    run(1, 400);
    check("full_issued",   64'(bus.issued_count), 64'(9));
    check("full_alldone",  64'(done_pulses),      64'(1));

    // timeout: two ops, no done_out
    step(0, '0, 0, 0, 1);
    done_pulses = 0;
    step(1, mk_op(8'h21, 1, 1, 1, 1, 1, 1), 0, 0, 0);
    step(1, mk_op(8'h22, 2, 2, 2, 2, 2, 2), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 70; i++) step(0, '0, 0, 0, 0);
    check("tmo_err",     64'(bus.error_timeout), 64'(1));
    check("tmo_level",   64'(bus.fifo_level),    64'(0));
    check("tmo_busy",    64'(bus.busy),          64'(0));
    check("tmo_issued",  64'(bus.issued_count),  64'(1));
    check("tmo_alldone", 64'(done_pulses),       64'(0));

    // reset during the second WAIT (error_timeout still set from above)
    for (int i = 0; i < 4; i++) step(1, mk_op(8'h30 + 8'(i), 7, 7, 7, 7, 7, 7), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      bit rr;
      rr = (phase == P_SHOW) && (m_cnt == 2);
      step(0, '0, 0, resp(2) && !rr, rr);
      if (rr) break;
    end
    check("mid_rst_op",     64'(bus.op),            64'(0));
    check("mid_rst_level",  64'(bus.fifo_level),    64'(0));
    check("mid_rst_issued", 64'(bus.issued_count),  64'(0));
    check("mid_rst_err",    64'(bus.error_timeout), 64'(0));
    check("mid_rst_busy",   64'(bus.busy),          64'(0));

    // push during run
    done_pulses = 0;
    seen.delete();
    step(1, mk_op(8'h41, 1, 0, 1, 0, 1, 0), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 10 && phase != P_SHOW; i++) step(0, '0, 0, 0, 0);
    step(1, mk_op(8'h42, 0, 1, 0, 1, 0, 1), 0, 0, 0);
    check("pdr_no_early_done", 64'(done_pulses), 64'(0));
    run(3, 100);
    check("pdr_issued",  64'(bus.issued_count), 64'(2));
    check("pdr_alldone", 64'(done_pulses),      64'(1));
    check("pdr_ops",     64'(seen.size()),      64'(2));

    // randomized traffic; second half makes done_out rare to provoke timeouts
    have = 0;
    for (int c = 0; c < 3000; c++) begin
      bit s, dn, r;
      int dprob;
      dprob = (c < 1500) ? 5 : 60;
      if (!have && $urandom_range(0, 2) == 0) begin
        pend = $urandom;
        have = 1;
      end
      s  = ($urandom_range(0, 7) == 0);
      dn = ($urandom_range(0, dprob - 1) == 0);
      r  = ($urandom_range(0, 599) == 0);
      step(have, pend, s, dn, r);
      if (last_acc) have = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
